// File: rtl/seq_shifter.sv
// ----------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle barrel-shift replacement. It accepts one request, then shifts
//   the operand one bit per clock until the requested distance is reached,
//   and holds the result until the consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   request present on a / dir / arith / amt
//   in_ready   block can accept a request (IDLE only)
//   a          operand
//   dir        0: shift left, 1: shift right
//   arith      1: right shifts replicate the MSB (ignored for left shifts)
//   amt        shift distance, 0..WIDTH-1
//   out_valid  result on y is valid (DONE only)
//   out_ready  consumer accepts the result
//   y          data register (meaningful only while out_valid=1)
//   busy       high in any state other than IDLE
// ----------------------------------------------------------------------------
module seq_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             dir,
    input  logic             arith,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [WIDTH-1:0]   shift1;
    logic               accept;

    assign accept = in_valid && in_ready_q;

    // Single-bit step of the latched operation
    always_comb begin
        shift1 = '0;
        if (!dir_q) begin
            shift1 = {data_q[WIDTH-2:0], 1'b0};
        end else begin
            shift1 = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = a;
                    cnt_d   = amt;
                    dir_d   = dir;
                    arith_d = arith;
                    state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = shift1;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Handshake edge returns to IDLE; no accept can happen on it
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            arith_q     <= arith_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// ----------------------------------------------------------------------------
// tb_seq_shifter
//   Directed and randomized checks of seq_shifter against an arithmetic
//   shift model (<<, >>, >>>) with latency, handshake and reset checks.
// ----------------------------------------------------------------------------
module tb_seq_shifter;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic          dir;
    logic          arith;
    logic [AW-1:0] amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .dir       (dir),
        .arith     (arith),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one-step shift with plain operators
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] ra, input logic rdir,
                                               input logic rarith, input logic [AW-1:0] ramt);
        logic signed [W-1:0] s;
        s = $signed(ra);
        if (!rdir)       return W'({24'd0, ra} << ramt);
        else if (rarith) return W'(s >>> ramt);
        else             return W'(ra >> ramt);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at #1 after an edge with the DUT expected in IDLE
    task automatic run_req(input logic [W-1:0] ra, input logic rdir, input logic rarith,
                           input logic [AW-1:0] ramt, input int pre_gap, input int stall,
                           input bit pulse_in_stall, input bit iv_on_hs, input bit verbose);
        logic [W-1:0] exp_y;
        int lat;
        exp_y = ref_shift(ra, rdir, rarith, ramt);
        for (int i = 0; i < pre_gap; i++) begin
            in_valid = 1'b0;
            step();
        end
        if (verbose) chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = ra;
        dir       = rdir;
        arith     = rarith;
        amt       = ramt;
        out_ready = 1'b0;
        step();
        // Scramble inputs after the accept edge; the in-flight result must not move
        in_valid = 1'b0;
        a        = W'($urandom);
        dir      = 1'($urandom);
        arith    = 1'($urandom);
        amt      = AW'($urandom);
        if (verbose) chk("busy_after_accept", 32'(busy), 32'd1);
        if (verbose) chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            step();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'(ramt) + 32'd1);
        chk("y_result", 32'(y), 32'(exp_y));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = pulse_in_stall ? 1'($urandom) : 1'b0;
            step();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_y", 32'(y), 32'(exp_y));
        end
        out_ready = 1'b1;
        in_valid  = iv_on_hs;
        step();
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        if (verbose) chk("post_hs_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 8'hFF;
        dir       = 1'b0;
        arith     = 1'b0;
        amt       = '0;
        out_ready = 1'b1;

        // Held reset wins over a pending request
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_y", 32'(y), 32'd0);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        // Directed cases
        run_req(8'hB5, 1'b0, 1'b0, 3'd3, 0, 0, 1'b0, 1'b0, 1'b1);
        run_req(8'hB5, 1'b1, 1'b1, 3'd2, 0, 0, 1'b0, 1'b0, 1'b1);
        run_req(8'hB5, 1'b1, 1'b0, 3'd2, 1, 0, 1'b0, 1'b0, 1'b1);
        run_req(8'hB5, 1'b0, 1'b0, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1);
        run_req(8'h3C, 1'b1, 1'b0, 3'd4, 0, 5, 1'b1, 1'b1, 1'b1);
        run_req(8'h80, 1'b1, 1'b1, 3'd7, 0, 0, 1'b0, 1'b0, 1'b1);
        run_req(8'h01, 1'b0, 1'b0, 3'd7, 0, 0, 1'b0, 1'b0, 1'b1);

        // Reset during the second SHIFT cycle aborts without a result
        in_valid = 1'b1;
        a        = 8'hC3;
        dir      = 1'b0;
        arith    = 1'b0;
        amt      = 3'd5;
        step();
        in_valid = 1'b0;
        step();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("abort_in_ready", 32'(in_ready), 32'd1);
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_y", 32'(y), 32'd0);
        end
        rst       = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_req(8'h0F, 1'b0, 1'b0, 3'd1, 0, 0, 1'b0, 1'b0, 1'b1);

        // Random regression
        for (int n = 0; n < 10000; n++) begin
            logic [W-1:0]  ra;
            logic          rd, rar;
            logic [AW-1:0] rm;
            int gap, st;
            ra  = W'($urandom);
            rd  = 1'($urandom);
            rar = 1'($urandom);
            rm  = AW'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? 1 : 0;
            st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 0;
            run_req(ra, rd, rar, rm, gap, st, 1'b1, 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
